// File: rtl/word_unpacker_pkg.sv
// rtl/word_unpacker_pkg.sv - shared constants, state type and helpers for word_unpacker
package word_unpacker_pkg;

  localparam int DEF_WORD_W = 64;
  localparam int DEF_BEAT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Beat counter width; a single-beat word still needs one bit of counter.
  function automatic int cnt_width(input int nbeats);
    return (nbeats <= 2) ? 1 : $clog2(nbeats);
  endfunction

endpackage

// File: rtl/word_unpacker_beat_counter.sv
// rtl/word_unpacker_beat_counter.sv - modulo-NBEATS beat counter with clear and last flag
module beat_counter
  import word_unpacker_pkg::*;
#(
  parameter int NBEATS = DEF_WORD_W / DEF_BEAT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_last
);

  localparam int CNT_W = cnt_width(NBEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBEATS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment so a freshly loaded word always starts at beat 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_last = (cnt_q == LAST);

endmodule

// File: rtl/word_unpacker.sv
// rtl/word_unpacker.sv - unloads a wide word as a stream of narrow beats, LSB beat first
module word_unpacker
  import word_unpacker_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int BEAT_W = DEF_BEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int NBEATS = WORD_W / BEAT_W;

  if ((WORD_W % BEAT_W) != 0) begin : g_bad_ratio
    $error("word_unpacker: WORD_W must be an integer multiple of BEAT_W");
  end

  state_e            state_q;
  state_e            state_d;
  logic [WORD_W-1:0] buf_q;
  logic [WORD_W-1:0] buf_d;
  logic              at_last;
  logic              accept;
  logic              xfer;

  // Outputs are decoded from registered state only, so an async reset clears them at once.
  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? buf_q[BEAT_W-1:0] : '0;
  assign out_last  = out_valid && at_last;

  // A new word may load on the same edge the last beat leaves: no bubble between words.
  assign in_ready = (state_q == IDLE) || (at_last && out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // Next state and next shift-buffer contents.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          buf_d   = in_data;
        end
      end
      SEND: begin
        if (xfer) begin
          if (!at_last) begin
            buf_d = buf_q >> BEAT_W;
          end else if (accept) begin
            buf_d = in_data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and shift-buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  // Beat position within the held word; wraps to 0 after the last beat.
  beat_counter #(
    .NBEATS (NBEATS)
  ) u_beat_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .inc     (xfer),
    .at_last (at_last)
  );

endmodule

// File: tb/tb_word_unpacker.sv
// tb/tb_word_unpacker.sv - self-checking bench for word_unpacker against a beat-list model
module tb_word_unpacker;

  localparam int W = 64;
  localparam int B = 8;
  localparam int N = W / B;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [B-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] in_words[$];
  logic [B-1:0] obs_data[$];
  logic         obs_last[$];
  int           obs_cyc[$];
  logic         obs_inrdy[$];
  int           obs_acc[$];
  logic [B-1:0] stall_data[$];
  logic         stall_last[$];
  logic         stall_rdy[$];

  word_unpacker #(.WORD_W(W), .BEAT_W(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Model: beat i of the stream is byte (i mod N) of word (i / N), LSB first.
  function automatic logic [B-1:0] exp_beat(input int i);
    logic [W-1:0] w;
    w = in_words[i / N];
    return B'(w >> (B * (i % N)));
  endfunction

  function automatic logic exp_last(input int i);
    return (i % N) == (N - 1);
  endfunction

  // Producer/consumer driver: records what the DUT does, checks nothing itself.
  task automatic run(input int vpct, input int rpct, input int stall_beat, input int stall_len,
                     input int budget);
    int wi = 0;
    int cyc = 0;
    int stalled = 0;
    bit pend = 0;
    obs_data.delete(); obs_last.delete(); obs_cyc.delete(); obs_inrdy.delete();
    obs_acc.delete(); stall_data.delete(); stall_last.delete(); stall_rdy.delete();
    while (obs_data.size() < in_words.size() * N && cyc < budget) begin
      @(negedge clk);
      if (!pend) pend = (wi < in_words.size()) && ($urandom_range(99) < vpct);
      in_valid = pend;
      in_data  = pend ? in_words[wi] : '0;
      if (obs_data.size() == stall_beat && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = ($urandom_range(99) < rpct);
      end
      #1;
      obs_inrdy.push_back(in_ready);
      if (out_valid && !out_ready && obs_data.size() == stall_beat) begin
        stall_data.push_back(out_data);
        stall_last.push_back(out_last);
        stall_rdy.push_back(in_ready);
      end
      if (out_valid && out_ready) begin
        obs_data.push_back(out_data);
        obs_last.push_back(out_last);
        obs_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        obs_acc.push_back(cyc);
        wi++;
        pend = 0;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_word();
    in_words = '{64'h0706050403020100};
    run(100, 100, -1, 0, 50);
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (i >= obs_data.size()) begin
        n_err++; $display("FAIL single_beat%0d: got none want %h", i, exp_beat(i));
      end else if (obs_data[i] !== exp_beat(i) || obs_last[i] !== exp_last(i) || obs_cyc[i] !== i + 1) begin
        n_err++; $display("FAIL single_beat%0d: got %h last=%b cyc=%0d want %h last=%b cyc=%0d",
                          i, obs_data[i], obs_last[i], obs_cyc[i], exp_beat(i), exp_last(i), i + 1);
      end
    end
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL single_after: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    in_words = '{{8{8'h11}}, {8{8'h22}}};
    run(100, 100, -1, 0, 60);
    n_cmp++; if (obs_data.size() !== 2 * N || obs_cyc[2*N-1] - obs_cyc[0] !== 2 * N - 1) begin
      n_err++; $display("FAIL b2b_span: got %0d beats want %0d with no gap", obs_data.size(), 2 * N);
    end else begin
      for (int i = 0; i < 2 * N; i++) begin
        n_cmp++; if (obs_data[i] !== exp_beat(i) || obs_last[i] !== exp_last(i)) begin
          n_err++; $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i], exp_beat(i), exp_last(i));
        end
      end
      for (int i = 0; i < N; i++) begin
        n_cmp++; if (obs_inrdy[obs_cyc[i]] !== (i == N - 1)) begin
          n_err++; $display("FAIL b2b_in_ready_beat%0d: got %b want %b", i, obs_inrdy[obs_cyc[i]], i == N - 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    in_words = '{64'hFFEEDDCCBBAA9988};
    run(100, 100, 3, 3, 60);
    n_cmp++; if (stall_data.size() !== 3) begin
      n_err++; $display("FAIL bp_stall_len: got %0d want 3", stall_data.size());
    end
    for (int i = 0; i < stall_data.size(); i++) begin
      n_cmp++; if (stall_data[i] !== 8'hBB || stall_last[i] !== 1'b0 || stall_rdy[i] !== 1'b0) begin
        n_err++; $display("FAIL bp_hold%0d: got %h last=%b in_ready=%b want bb/0/0", i, stall_data[i], stall_last[i], stall_rdy[i]);
      end
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++; if (i >= obs_data.size() || obs_data[i] !== exp_beat(i) || obs_last[i] !== exp_last(i)) begin
        n_err++; $display("FAIL bp_beat%0d: got %h want %h", i, (i < obs_data.size()) ? obs_data[i] : 8'hxx, exp_beat(i));
      end
    end
  endtask

  task automatic test_busy_ignored();
    in_words = '{64'h0F0E0D0C0B0A0908, 64'hDEADBEEFDEADBEEF};
    run(100, 100, -1, 0, 60);
    n_cmp++; if (obs_data.size() !== 2 * N) begin
      n_err++; $display("FAIL busy_count: got %0d want %0d", obs_data.size(), 2 * N);
    end else begin
      n_cmp++; if (obs_inrdy[obs_cyc[2]] !== 1'b0) begin
        n_err++; $display("FAIL busy_in_ready_beat2: got %b want 0", obs_inrdy[obs_cyc[2]]);
      end
      n_cmp++; if (obs_acc.size() !== 2 || obs_acc[1] !== obs_cyc[N-1]) begin
        n_err++; $display("FAIL busy_accept_cycle: got %0d want %0d", (obs_acc.size() > 1) ? obs_acc[1] : -1, obs_cyc[N-1]);
      end
      for (int i = 0; i < 2 * N; i++) begin
        n_cmp++; if (obs_data[i] !== exp_beat(i) || obs_last[i] !== exp_last(i)) begin
          n_err++; $display("FAIL busy_beat%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i], exp_beat(i), exp_last(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [W-1:0] w;
    w = {$urandom, $urandom};
    @(negedge clk); in_valid = 1'b1; in_data = w; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    @(negedge clk); out_ready = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== w[4*B +: B]) begin
      n_err++; $display("FAIL rst_mid_beat4: got %b/%h want 1/%h", out_valid, out_data, w[4*B +: B]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_async: got %b/%h/%b want 0/00/0", out_valid, out_data, out_last);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    in_words = '{{$urandom, $urandom}};
    run(100, 100, -1, 0, 50);
    for (int i = 0; i < N; i++) begin
      n_cmp++; if (i >= obs_data.size() || obs_data[i] !== exp_beat(i) || obs_last[i] !== exp_last(i)) begin
        n_err++; $display("FAIL rst_mid_next_beat%0d: got %h want %h", i, (i < obs_data.size()) ? obs_data[i] : 8'hxx, exp_beat(i));
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      in_words.delete();
      for (int k = 0; k < 5; k++) in_words.push_back({$urandom, $urandom});
      run(40 + 25 * r, 35 + 30 * r, -1, 0, 2000);
      n_cmp++; if (obs_data.size() !== in_words.size() * N) begin
        n_err++; $display("FAIL rand%0d_count: got %0d want %0d", r, obs_data.size(), in_words.size() * N);
      end
      for (int i = 0; i < obs_data.size(); i++) begin
        n_cmp++; if (obs_data[i] !== exp_beat(i) || obs_last[i] !== exp_last(i)) begin
          n_err++; $display("FAIL rand%0d_beat%0d: got %h/%b want %h/%b", r, i, obs_data[i], obs_last[i], exp_beat(i), exp_last(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_busy_ignored();
    test_reset_mid_word();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
